// File: rtl/md_pos_pkg.sv
// Shared definitions for the position-cache readout path.
//   - Width/depth defaults for the cache geometry (per-axis offset width,
//     particle ID / cache address width, number of cache entries).
//   - Depth of the output skid buffer.
//   - Readout FSM state encoding.
package md_pos_pkg;

    localparam int OFFSET_WIDTH_DEF      = 29;
    localparam int PARTICLE_ID_WIDTH_DEF = 7;
    localparam int POS_CACHE_DEPTH_DEF   = 128;

    // Entries held by the output skid buffer; also the read-credit limit.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ_CNT = 3'd1,
        WAIT_CNT = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        FINISH   = 3'd5
    } rd_state_t;

endpackage

// File: rtl/pos_cache_reader_if.sv
// Bus bundle between the position-cache reader, the position cache and the
// downstream particle consumer.
//   rd_en / rd_addr   : read request to the cache (reader drives)
//   rd_data           : cache read data, valid one cycle after rd_en
//   out_valid / out_ready / out_id / out_pos : particle stream handshake
// Modports: master = reader side, slave = cache/consumer side.
interface pos_cache_reader_if
    import md_pos_pkg::*;
#(
    parameter int OFFSET_WIDTH      = OFFSET_WIDTH_DEF,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF
);

    logic                          rd_en;
    logic [PARTICLE_ID_WIDTH-1:0]  rd_addr;
    logic [3*OFFSET_WIDTH-1:0]     rd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [PARTICLE_ID_WIDTH-1:0]  out_id;
    logic [3*OFFSET_WIDTH-1:0]     out_pos;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_id,
        output out_pos
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_id,
        input  out_pos
    );

endinterface

// File: rtl/pos_skid_fifo.sv
// Two-entry registered FIFO carrying a position word tagged with its particle ID.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_in_valid / o_in_ready           : write handshake
//   i_in_data / i_in_id               : write payload
//   o_out_valid / i_out_ready         : read handshake
//   o_out_data / o_out_id             : head-of-queue payload (register outputs)
//   o_count                           : current occupancy (0..2)
// The head entry stays put until it is popped, so the read side is stable
// while stalled.
module pos_skid_fifo #(
    parameter int DATA_WIDTH = 87,
    parameter int ID_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic [ID_WIDTH-1:0]   i_in_id,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ID_WIDTH-1:0]   o_out_id,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [ID_WIDTH-1:0]   r_id   [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_data[r_rd_ptr];
    assign o_out_id    = r_id[r_rd_ptr];
    assign o_count     = r_count;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= {DATA_WIDTH{1'b0}};
                r_id[i]   <= {ID_WIDTH{1'b0}};
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= i_in_data;
                r_id[r_wr_ptr]   <= i_in_id;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pos_cache_reader.sv
// Reads the particle count from cache address 0, then streams addresses 1..N
// out of the position cache as (id, {z,y,x}) tuples through a 2-entry skid
// buffer with valid/ready backpressure.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : one-cycle pulse starting a readout (ignored while busy)
//   o_particle_count  : N latched from address 0 (clamped to depth-1)
//   o_busy            : readout in progress
//   o_done            : one-cycle pulse after the last transfer
//   bus               : cache read port and particle stream (master modport)
module pos_cache_reader
    import md_pos_pkg::*;
#(
    parameter int OFFSET_WIDTH      = OFFSET_WIDTH_DEF,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
    parameter int POS_CACHE_DEPTH   = POS_CACHE_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    output logic [PARTICLE_ID_WIDTH-1:0] o_particle_count,
    output logic                         o_busy,
    output logic                         o_done,
    pos_cache_reader_if.master           bus
);

    localparam int            PW        = PARTICLE_ID_WIDTH;
    localparam int            DW        = 3 * OFFSET_WIDTH;
    localparam logic [PW-1:0] MAX_N     = PW'(POS_CACHE_DEPTH - 1);
    localparam logic [PW-1:0] ADDR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] ADDR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    rd_state_t     r_state;
    rd_state_t     w_state_nxt;
    logic [PW-1:0] r_count;
    logic [PW-1:0] r_next_addr;
    logic          r_inflight;
    logic [PW-1:0] r_inflight_id;

    logic          w_rd_en;
    logic [PW-1:0] w_rd_addr;
    logic          w_issue;
    logic [PW-1:0] w_raw_n;
    logic [PW-1:0] w_clamped_n;
    logic          w_skid_in_ready;
    logic          w_skid_valid;
    logic [PW-1:0] w_skid_id;
    logic [DW-1:0] w_skid_pos;
    logic [1:0]    w_skid_cnt;
    logic          w_pop;
    logic          w_credit_ok;
    logic          w_drain_empty;

    assign w_raw_n     = bus.rd_data[PW-1:0];
    assign w_clamped_n = (w_raw_n > MAX_N) ? MAX_N : w_raw_n;
    assign w_pop       = w_skid_valid && bus.out_ready;

    // A new read may go out only if, counting the entry leaving this cycle,
    // the buffer plus the read already on the cache bus leave a free slot
    // for it by the time its data arrives.
    assign w_credit_ok = ((3'(w_skid_cnt) + 3'(r_inflight)) < (3'(SKID_DEPTH) + 3'(w_pop)))
                         && (w_skid_in_ready || w_pop);

    // Buffer will be empty after this edge and no data is still coming back.
    assign w_drain_empty = ((3'(w_skid_cnt) + 3'(r_inflight)) == 3'(w_pop));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and cache read request decode
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = ADDR_ZERO;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = READ_CNT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            READ_CNT: begin
                w_rd_en     = 1'b1;
                w_rd_addr   = ADDR_ZERO;
                w_state_nxt = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (w_clamped_n == ADDR_ZERO) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_credit_ok) begin
                    w_issue   = 1'b1;
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_next_addr;
                    if (r_next_addr == r_count) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Count latch, ascending address counter and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= ADDR_ZERO;
            r_next_addr   <= ADDR_ZERO;
            r_inflight    <= 1'b0;
            r_inflight_id <= ADDR_ZERO;
        end else begin
            if (r_state == WAIT_CNT) begin
                r_count     <= w_clamped_n;
                r_next_addr <= ADDR_ONE;
            end else if (w_issue && (r_next_addr != r_count)) begin
                // Stops at N, so the counter never wraps.
                r_next_addr <= r_next_addr + ADDR_ONE;
            end else begin
                r_next_addr <= r_next_addr;
            end
            r_inflight    <= w_issue;
            r_inflight_id <= w_issue ? r_next_addr : ADDR_ZERO;
        end
    end

    pos_skid_fifo #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (r_inflight),
        .o_in_ready  (w_skid_in_ready),
        .i_in_data   (bus.rd_data),
        .i_in_id     (r_inflight_id),
        .o_out_valid (w_skid_valid),
        .i_out_ready (bus.out_ready),
        .o_out_data  (w_skid_pos),
        .o_out_id    (w_skid_id),
        .o_count     (w_skid_cnt)
    );

    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = w_rd_addr;
    assign bus.out_valid  = w_skid_valid;
    assign bus.out_id     = w_skid_id;
    assign bus.out_pos    = w_skid_pos;
    assign o_particle_count = r_count;
    assign o_busy         = (r_state != IDLE);
    assign o_done         = (r_state == FINISH);

endmodule

// File: tb/tb_pos_cache_reader.sv
// Self-checking bench for pos_cache_reader: a behavioural cache model with
// one-cycle read latency, and a scoreboard built from the expected transfer
// list (ids 1..N with their stored positions) plus directed timing checks.
module tb_pos_cache_reader;
    import md_pos_pkg::*;

    localparam int OW    = 29;
    localparam int PW    = 7;
    localparam int DW    = 3 * OW;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] pcount;
    logic          busy;
    logic          done;

    pos_cache_reader_if #(.OFFSET_WIDTH(OW), .PARTICLE_ID_WIDTH(PW)) bif ();

    pos_cache_reader #(
        .OFFSET_WIDTH      (OW),
        .PARTICLE_ID_WIDTH (PW),
        .POS_CACHE_DEPTH   (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (start),
        .o_particle_count (pcount),
        .o_busy           (busy),
        .o_done           (done),
        .bus              (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] id;
        logic [DW-1:0] pos;
    } item_t;

    logic [DW-1:0] mem [DEPTH];
    item_t         exp_q [$];
    int            rd_cyc_q [$];
    int            xfer_cyc_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    int cyc, n_exp, exp_rd_addr, n_rd, n_stream_rd, n_xfer;
    int done_cnt, done_cyc, last_xfer_cyc, first_valid_cyc;
    bit            stalled;
    logic [PW-1:0] held_id;
    logic [DW-1:0] held_pos;
    logic          prev_en;
    logic [PW-1:0] prev_addr;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return (c % 3 == 0);
        endcase
    endfunction

    task automatic model_reset(input int n);
        exp_q.delete();
        for (int a = 1; a <= n; a++) exp_q.push_back('{id: PW'(a), pos: mem[a]});
        n_exp = n; exp_rd_addr = 0; n_rd = 0; n_stream_rd = 0; n_xfer = 0;
        done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
        stalled = 1'b0;
        rd_cyc_q.delete();
        xfer_cyc_q.delete();
    endtask

    // Compare the current cycle's outputs against the scoreboard.
    task automatic observe();
        check_eq("in_flight_le2", 128'((n_stream_rd - n_xfer) <= 2), 128'(1));
        if (cyc == 1) check_eq("busy_cycle1", 128'(busy), 128'(1));
        if (bif.rd_en) begin
            check_eq("rd_addr_seq", 128'(bif.rd_addr), 128'(exp_rd_addr));
            check_eq("rd_within_n", 128'(exp_rd_addr <= n_exp), 128'(1));
            if (exp_rd_addr > 0) n_stream_rd++;
            exp_rd_addr++;
            n_rd++;
            rd_cyc_q.push_back(cyc);
        end else begin
            check_eq("rd_addr_idle", 128'(bif.rd_addr), 128'(0));
        end
        if (stalled) begin
            check_eq("stall_valid", 128'(bif.out_valid), 128'(1));
            check_eq("stall_id", 128'(bif.out_id), 128'(held_id));
            check_eq("stall_pos", 128'(bif.out_pos), 128'(held_pos));
        end
        if (bif.out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bif.out_ready) begin
                check_eq("xfer_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    check_eq("xfer_id", 128'(bif.out_id), 128'(exp_q[0].id));
                    check_eq("xfer_pos", 128'(bif.out_pos), 128'(exp_q[0].pos));
                    void'(exp_q.pop_front());
                end
                n_xfer++;
                last_xfer_cyc = cyc;
                xfer_cyc_q.push_back(cyc);
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                held_id  = bif.out_id;
                held_pos = bif.out_pos;
            end
        end else begin
            stalled = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // One clock: apply inputs, optionally check, then advance; the cache model
    // returns data for the address requested in the cycle just ended.
    task automatic cycle(input logic st, input logic rd_rdy, input bit chk_on);
        start         = st;
        bif.out_ready = rd_rdy;
        #1;
        if (chk_on) observe();
        prev_en   = bif.rd_en;
        prev_addr = bif.rd_addr;
        @(posedge clk);
        #1;
        bif.rd_data = prev_en ? mem[prev_addr] : DW'({$urandom, $urandom, $urandom});
        start = 1'b0;
        cyc++;
    endtask

    task automatic load_cache(input logic [7:0] raw, output int n);
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'({$urandom, $urandom, $urandom});
        mem[0][7:0] = raw;
        n = int'(raw[6:0]);
        if (n > DEPTH - 1) n = DEPTH - 1;
    endtask

    task automatic readout(input logic [7:0] raw, input int mode, input int restart_at);
        int n;
        int guard;
        load_cache(raw, n);
        model_reset(n);
        cyc = 0;
        cycle(1'b1, rdy(mode, cyc), 1'b1);
        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            cycle(cyc == restart_at, rdy(mode, cyc), 1'b1);
            guard++;
        end
        check_eq("done_seen", 128'(done_cnt), 128'(1));
        repeat (3) cycle(1'b0, rdy(mode, cyc), 1'b1);
        check_eq("done_once", 128'(done_cnt), 128'(1));
        check_eq("all_xfers", 128'(n_xfer), 128'(n));
        check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
        check_eq("rd_count", 128'(n_rd), 128'(n + 1));
        check_eq("particle_count", 128'(pcount), 128'(n));
        check_eq("busy_after", 128'(busy), 128'(0));
        if (n > 0) check_eq("done_after_last", 128'(done_cyc), 128'(last_xfer_cyc + 1));
        if (mode == 0) begin
            check_eq("first_valid", 128'(first_valid_cyc), 128'(n == 0 ? -1 : 5));
            check_eq("throughput", 128'(last_xfer_cyc), 128'(n == 0 ? -1 : 4 + n));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, 128'(bif.rd_en), 128'(0));
        check_eq({tag, "_rd_addr"}, 128'(bif.rd_addr), 128'(0));
        check_eq({tag, "_out_valid"}, 128'(bif.out_valid), 128'(0));
        check_eq({tag, "_out_id"}, 128'(bif.out_id), 128'(0));
        check_eq({tag, "_out_pos"}, 128'(bif.out_pos), 128'(0));
        check_eq({tag, "_pcount"}, 128'(pcount), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        int n;
        int guard;
        int exp_rd [4];
        int exp_xf [3];
        exp_rd = '{1, 3, 4, 5};
        exp_xf = '{5, 6, 7};
        rst = 1'b1; start = 1'b0; bif.out_ready = 1'b0; bif.rd_data = '0; cyc = 0;
        model_reset(0);
        @(posedge clk); #1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b0);

        // Three particles, consumer always ready: exact cycle timing.
        readout(8'd3, 0, -1);
        check_eq("rd_cycles_n", 128'(rd_cyc_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < rd_cyc_q.size(); i++) check_eq("rd_cycle", 128'(rd_cyc_q[i]), 128'(exp_rd[i]));
        check_eq("xf_cycles_n", 128'(xfer_cyc_q.size()), 128'(3));
        for (int i = 0; i < 3 && i < xfer_cyc_q.size(); i++) check_eq("xfer_cycle", 128'(xfer_cyc_q[i]), 128'(exp_xf[i]));
        check_eq("done_cycle", 128'(done_cyc), 128'(8));

        // Empty cache, backpressure pattern, truncation/maximum counts.
        readout(8'd0, 0, -1);
        readout(8'd5, 2, -1);
        readout(8'd200, 0, -1);
        readout(8'd127, 0, -1);

        // Second start while busy is ignored.
        readout(8'd6, 0, 4);
        readout(8'd9, 1, 7);

        // Reset dominates a same-cycle start.
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("rst_vs_start_busy", 128'(busy), 128'(0));
        check_eq("rst_vs_start_rd_en", 128'(bif.rd_en), 128'(0));
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("rst_vs_start_idle", 128'(busy), 128'(0));

        // Abort after two of four transfers, then a clean readout.
        load_cache(8'd4, n);
        model_reset(n);
        cyc = 0;
        cycle(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (n_xfer < 2 && guard < 100) begin
            cycle(1'b0, 1'b1, 1'b1);
            guard++;
        end
        check_eq("abort_reached_2", 128'(n_xfer), 128'(2));
        rst = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0);
            check_eq("abort_no_done", 128'(done), 128'(0));
        end
        readout(8'd4, 0, -1);

        // Randomized counts and backpressure.
        for (int r = 0; r < 6; r++) begin
            readout(8'($urandom_range(0, 24)), 1, (r == 2) ? 5 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
